infra_reset_sequencer: RTL



---
 rtl/infra_seq_pkg.sv | 23 ++
 rtl/infra_reset_sequencer_sync2.sv | 25 ++
 rtl/infra_reset_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/infra_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, counter and
// retry widths, and the registered output bundle.
package infra_seq_pkg;
  localparam int CNT_W   = 16;
  localparam int RETRY_W = 4;

  // Encodings are exported on seq_state, so values are fixed. 6 and 7 are illegal.
  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_IDLY_RST  = 3'd2,
    ST_WAIT_RDY  = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic idelay_rst;
    logic user_rst;
    logic done;
    logic fault;
  } seq_out_t;
endpackage

// File: rtl/infra_reset_sequencer_sync2.sv
// Two-flop synchronizer, reset to 0.
//   clk_i  : destination clock
//   rst_i  : async active-high reset
//   d_i    : asynchronous input
//   q_o    : synchronized output, 2 edges after d_i changes
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      q_q    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_q    <= meta_q;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/infra_reset_sequencer.sv
// Power-up / recovery sequencer for the clock and IDELAYCTRL infrastructure.
// Waits for a stable clock-manager lock, pulses the IDELAYCTRL reset, waits
// for idelay_rdy (retrying on timeout), then releases the user reset.
//   sys_clk / sys_rst : clock and async active-high reset
//   sys_clk_lock      : clock-manager lock (async)
//   idelay_rdy        : IDELAYCTRL ready (async)
//   soft_rst          : software re-sequence request (level, sys_clk domain)
//   idelay_rst        : reset to IDELAYCTRL
//   user_rst          : reset for all user logic
//   seq_done          : high only in RUN
//   seq_fault         : high only in FAULT
//   retry_count       : IDELAY retries used (cumulative until sys_rst/soft_rst)
//   seq_state         : current state encoding
module infra_reset_sequencer
  import infra_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int IDELAY_RST_CYCLES  = 16,
  parameter int RDY_TIMEOUT        = 4096,
  parameter int MAX_RETRIES        = 3
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               sys_clk_lock,
  input  logic               idelay_rdy,
  input  logic               soft_rst,
  output logic               idelay_rst,
  output logic               user_rst,
  output logic               seq_done,
  output logic               seq_fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [2:0]         seq_state
);
  localparam logic [CNT_W-1:0]   LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   IRST_LAST = CNT_W'(IDELAY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RDY_LAST  = CNT_W'(RDY_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic lock_s, rdy_s;

  sync2 u_sync_lock (.clk_i(sys_clk), .rst_i(sys_rst), .d_i(sys_clk_lock), .q_o(lock_s));
  sync2 u_sync_rdy  (.clk_i(sys_clk), .rst_i(sys_rst), .d_i(idelay_rdy),   .q_o(rdy_s));

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  seq_out_t           out_q, out_d;

  // State register; outputs are registered from the next state so they
  // move on the same edge as seq_state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      retry_q <= '0;
      out_q   <= '{idelay_rst: 1'b1, user_rst: 1'b1, done: 1'b0, fault: 1'b0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      out_q   <= out_d;
    end
  end

  // Next state. Lock loss is checked before any timeout/ready so a
  // coinciding timeout never bumps retry_count.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (soft_rst) begin
      state_d = ST_WAIT_LOCK;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: if (lock_s) state_d = ST_STABLE;
        ST_STABLE: begin
          if (!lock_s)                 state_d = ST_WAIT_LOCK;
          else if (cnt_q == LOCK_LAST) state_d = ST_IDLY_RST;
        end
        ST_IDLY_RST: begin
          if (!lock_s)                 state_d = ST_WAIT_LOCK;
          else if (cnt_q == IRST_LAST) state_d = ST_WAIT_RDY;
        end
        ST_WAIT_RDY: begin
          if (!lock_s)    state_d = ST_WAIT_LOCK;
          else if (rdy_s) state_d = ST_RUN;
          else if (cnt_q == RDY_LAST) begin
            if (retry_q == RETRY_MAX) state_d = ST_FAULT;
            else begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = ST_IDLY_RST;
            end
          end
        end
        ST_RUN:   if (!lock_s || !rdy_s) state_d = ST_WAIT_LOCK;
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_WAIT_LOCK;
      endcase
    end
  end

  // Shared counter restarts on every state change.
  assign cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

  // Outputs decoded from the next state; illegal encodings look like reset.
  always_comb begin
    out_d = '{idelay_rst: 1'b1, user_rst: 1'b1, done: 1'b0, fault: 1'b0};
    case (state_d)
      ST_WAIT_RDY: out_d.idelay_rst = 1'b0;
      ST_RUN: begin
        out_d.idelay_rst = 1'b0;
        out_d.user_rst   = 1'b0;
        out_d.done       = 1'b1;
      end
      ST_FAULT: out_d.fault = 1'b1;
      default: ;
    endcase
  end

  assign idelay_rst  = out_q.idelay_rst;
  assign user_rst    = out_q.user_rst;
  assign seq_done    = out_q.done;
  assign seq_fault   = out_q.fault;
  assign retry_count = retry_q;
  assign seq_state   = state_q;
endmodule
